// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART memory loader.
// Holds the frame marker and command codes, the oversampling factor and the
// state encodings of the byte receiver and the frame FSM.
package uart_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;
  localparam logic [7:0] CMD_HALT  = 8'h03;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    F_IDLE,
    F_CMD,
    F_ADDR,
    F_DATA,
    F_CHK,
    F_EXEC
  } frame_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART byte receiver with 16x oversampling.
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   dvsr         - one tick every dvsr+1 clocks
//   serial_in    - raw UART line (idle high), double-flopped internally
//   tick         - oversample tick, also used by the loader for its timeout
//   byte_valid   - one-clock strobe, byte_data holds the received byte
//   byte_data    - last received byte
//   frame_err    - one-clock strobe when the stop bit was sampled low
module uart_rx_core
  import uart_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dvsr,
  input  logic        serial_in,
  output logic        tick,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_err
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  // The falling edge is seen two clocks late through the synchronizer, so the
  // start bit is resampled on the 7th tick to land near the middle of the bit.
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 2);

  logic [31:0] div_q, div_d;
  logic [1:0]  sync_q;
  logic        prev_q;
  logic        line, fall;
  rx_state_t   state_q, state_d;
  logic [3:0]  tcnt_q, tcnt_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [7:0]  shreg_q, shreg_d;

  // Using >= lets a divisor lowered below the running count wrap immediately.
  assign tick  = (div_q == dvsr);
  assign div_d = (div_q >= dvsr) ? 32'd0 : div_q + 32'd1;

  assign line      = sync_q[1];
  assign fall      = prev_q & ~line;
  assign byte_data = shreg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q   <= '0;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
    end else begin
      div_q   <= div_d;
      sync_q  <= {sync_q[0], serial_in};
      prev_q  <= line;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bcnt_d     = bcnt_q;
    shreg_d    = shreg_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (fall) begin
          state_d = RX_START;
          tcnt_d  = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (tcnt_q == MID_TICK) begin
            tcnt_d  = '0;
            bcnt_d  = '0;
            state_d = line ? RX_IDLE : RX_DATA;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (tcnt_q == LAST_TICK) begin
            tcnt_d  = '0;
            shreg_d = {line, shreg_q[7:1]};
            if (bcnt_q == 3'd7) state_d = RX_STOP;
            else                bcnt_d  = bcnt_q + 3'd1;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (tcnt_q == LAST_TICK) begin
            state_d = RX_IDLE;
            if (line) byte_valid = 1'b1;
            else      frame_err  = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_mem_loader.sv
// Boot/debug loader: decodes UART command frames
//   A5, CMD, ADDR[4] (LE), DATA[4] (LE), CHK = XOR(CMD, ADDR, DATA)
// into single-cycle memory word writes, and holds the core in reset until RUN.
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   dvsr       - UART oversample divisor (tick every dvsr+1 clocks)
//   serial_in  - UART line, idle high
//   mem_we     - one-cycle write strobe; mem_addr (word aligned) / mem_wd
//   cpu_hold   - core reset hold, 1 out of reset, cleared by RUN, set by HALT
//   busy       - frame FSM not idle
//   err_cnt    - saturating count of rejected frames
// ADDR_W must be in 3..32.
module uart_mem_loader
  import uart_loader_pkg::*;
#(
  parameter int TIMEOUT_BYTES = 4,
  parameter int ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dvsr,
  input  logic              serial_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              cpu_hold,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  // One byte-time is 10 bit-times of OVERSAMPLE ticks each.
  localparam int            TO_TICKS = TIMEOUT_BYTES * 10 * OVERSAMPLE;
  localparam int            TO_W     = $clog2(TO_TICKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_TICKS - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic        tick, byte_valid, frame_err;
  logic [7:0]  byte_data;

  frame_state_t      state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [TO_W-1:0]   tocnt_q, tocnt_d;
  logic [7:0]        err_q, err_d;
  logic              hold_q, hold_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       mwd_q, mwd_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        chk_q, chk_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              chk_ok_q, chk_ok_d;
  logic              in_frame, timeout, bump_err;

  uart_rx_core u_rx (
    .clk        (clk),
    .rst        (rst),
    .dvsr       (dvsr),
    .serial_in  (serial_in),
    .tick       (tick),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  // Abort conditions only apply while collecting bytes; F_EXEC always completes.
  assign in_frame = (state_q != F_IDLE) && (state_q != F_EXEC);
  assign timeout  = in_frame && tick && !byte_valid && (tocnt_q == TO_LAST);

  assign mem_we   = we_q;
  assign mem_addr = maddr_q;
  assign mem_wd   = mwd_q;
  assign cpu_hold = hold_q;
  assign busy     = (state_q != F_IDLE);
  assign err_cnt  = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= F_IDLE;
      bcnt_q  <= '0;
      tocnt_q <= '0;
      err_q   <= '0;
      hold_q  <= 1'b1;
      we_q    <= 1'b0;
      maddr_q <= '0;
      mwd_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      tocnt_q <= tocnt_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      mwd_q   <= mwd_d;
    end
  end

  // Frame payload capture; always rewritten before it is consumed.
  always_ff @(posedge clk) begin
    cmd_q    <= cmd_d;
    chk_q    <= chk_d;
    addr_q   <= addr_d;
    data_q   <= data_d;
    chk_ok_q <= chk_ok_d;
  end

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    err_d    = err_q;
    hold_d   = hold_q;
    we_d     = 1'b0;
    maddr_d  = maddr_q;
    mwd_d    = mwd_q;
    cmd_d    = cmd_q;
    chk_d    = chk_q;
    addr_d   = addr_q;
    data_d   = data_q;
    chk_ok_d = chk_ok_q;
    bump_err = 1'b0;

    if (!in_frame)       tocnt_d = '0;
    else if (byte_valid) tocnt_d = '0;
    else if (tick)       tocnt_d = tocnt_q + 1'b1;
    else                 tocnt_d = tocnt_q;

    unique case (state_q)
      F_IDLE: begin
        if (byte_valid && byte_data == SYNC_BYTE) begin
          state_d = F_CMD;
          chk_d   = '0;
        end
      end
      F_CMD: begin
        if (byte_valid) begin
          cmd_d   = byte_data;
          chk_d   = chk_q ^ byte_data;
          bcnt_d  = '0;
          state_d = F_ADDR;
        end
      end
      F_ADDR: begin
        if (byte_valid) begin
          addr_d[{bcnt_q, 3'b000} +: 8] = byte_data;
          chk_d  = chk_q ^ byte_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = F_DATA;
        end
      end
      F_DATA: begin
        if (byte_valid) begin
          data_d[{bcnt_q, 3'b000} +: 8] = byte_data;
          chk_d  = chk_q ^ byte_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = F_CHK;
        end
      end
      F_CHK: begin
        if (byte_valid) begin
          chk_ok_d = (byte_data == chk_q);
          state_d  = F_EXEC;
        end
      end
      F_EXEC: begin
        state_d = F_IDLE;
        if (chk_ok_q && cmd_q == CMD_WRITE) begin
          we_d    = 1'b1;
          maddr_d = addr_q[ADDR_W-1:0] & ~ADDR_W'(3);
          mwd_d   = data_q;
        end else if (chk_ok_q && cmd_q == CMD_RUN) begin
          hold_d = 1'b0;
        end else if (chk_ok_q && cmd_q == CMD_HALT) begin
          hold_d = 1'b1;
        end else begin
          bump_err = 1'b1;
        end
      end
      default: state_d = F_IDLE;
    endcase

    if (in_frame && (frame_err || timeout)) begin
      state_d  = F_IDLE;
      bump_err = 1'b1;
    end

    if (bump_err) err_d = sat_inc(err_q);
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
module tb_uart_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] dvsr = 32'd0;
  logic        serial_in = 1'b1;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        cpu_hold;
  logic        busy;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  uart_mem_loader #(.TIMEOUT_BYTES(4), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .dvsr      (dvsr),
    .serial_in (serial_in),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: write pulses, received bytes and write latency in clocks.
  int cyc = 0;
  int we_pulses = 0;
  int bv_count = 0;
  int bv_cyc = 0;
  int we_lat = -1;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (dut.byte_valid) begin
      bv_count++;
      bv_cyc = cyc;
    end
    if (mem_we) begin
      we_pulses++;
      we_lat = cyc - bv_cyc;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [31:0] a,
                                            input logic [31:0] d);
    logic [7:0] c;
    c = cmd;
    for (int i = 0; i < 4; i++) c = c ^ a[8*i +: 8] ^ d[8*i +: 8];
    return c;
  endfunction

  // Stop bit is shortened to 12 ticks; it is sampled about 8 ticks in.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    int bt;
    bt = 16 * (int'(dvsr) + 1);
    serial_in = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (bt) @(negedge clk);
    end
    serial_in = stop;
    repeat (bt * 3 / 4) @(negedge clk);
    serial_in = 1'b1;
    if (!stop) repeat (2 * (int'(dvsr) + 1)) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                            input bit use_chk, input logic [7:0] chk);
    logic [7:0] c;
    c = use_chk ? chk : frame_chk(cmd, a, d);
    send_byte(8'hA5, 1'b1);
    send_byte(cmd, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
    send_byte(c, 1'b1);
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] dv;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    bit          use_chk;
    logic [7:0]  chk;
    int          exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    logic        exp_hold;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int w0;
    int b0;

    vecs[0] = '{32'd3, 8'h01, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 8'h00, 1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 8'd0};
    vecs[1] = '{32'd0, 8'h01, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 8'h00, 0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 8'd1};
    vecs[2] = '{32'd0, 8'h02, 32'h0000_0000, 32'h0000_0000, 1'b1, 8'h02, 0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 8'd1};
    vecs[3] = '{32'd0, 8'h01, 32'h0000_0203, 32'hA5A5_A5A5, 1'b0, 8'h00, 1, 32'h0000_0200, 32'hA5A5_A5A5, 1'b0, 8'd1};
    vecs[4] = '{32'd0, 8'h03, 32'h1111_2222, 32'h3333_4444, 1'b0, 8'h00, 0, 32'h0000_0200, 32'hA5A5_A5A5, 1'b1, 8'd1};
    vecs[5] = '{32'd0, 8'h07, 32'h0000_0010, 32'h0000_0020, 1'b0, 8'h00, 0, 32'h0000_0200, 32'hA5A5_A5A5, 1'b1, 8'd2};
    vecs[6] = '{32'd0, 8'h02, 32'h0000_0000, 32'h0000_0000, 1'b0, 8'h00, 0, 32'h0000_0200, 32'hA5A5_A5A5, 1'b0, 8'd2};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst mem_we",   32'(mem_we),   32'd0);
    check("rst mem_addr", mem_addr,      32'd0);
    check("rst mem_wd",   mem_wd,        32'd0);
    check("rst cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst busy",     32'(busy),     32'd0);
    check("rst err_cnt",  32'(err_cnt),  32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // Frame table
    for (int k = 0; k < 7; k++) begin
      dvsr = vecs[k].dv;
      w0 = we_pulses;
      send_frame(vecs[k].cmd, vecs[k].addr, vecs[k].data, vecs[k].use_chk, vecs[k].chk);
      check($sformatf("v%0d we_pulses", k), 32'(we_pulses - w0), 32'(vecs[k].exp_we));
      if (vecs[k].exp_we != 0) check($sformatf("v%0d we_latency", k), 32'(we_lat), 32'd2);
      check($sformatf("v%0d mem_addr", k), mem_addr, vecs[k].exp_addr);
      check($sformatf("v%0d mem_wd", k), mem_wd, vecs[k].exp_wd);
      check($sformatf("v%0d cpu_hold", k), 32'(cpu_hold), 32'(vecs[k].exp_hold));
      check($sformatf("v%0d err_cnt", k), 32'(err_cnt), 32'(vecs[k].exp_err));
      check($sformatf("v%0d busy", k), 32'(busy), 32'd0);
    end

    // Bad stop bit on the third address byte aborts; a clean frame then works
    dvsr = 32'd0;
    w0 = we_pulses;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h40, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (4) @(negedge clk);
    check("stoperr busy", 32'(busy), 32'd0);
    check("stoperr err_cnt", 32'(err_cnt), 32'd3);
    check("stoperr no write", 32'(we_pulses - w0), 32'd0);
    send_frame(8'h01, 32'h0000_0040, 32'hCAFE_F00D, 1'b0, 8'h00);
    check("after stoperr we_pulses", 32'(we_pulses - w0), 32'd1);
    check("after stoperr mem_addr", mem_addr, 32'h0000_0040);
    check("after stoperr mem_wd", mem_wd, 32'hCAFE_F00D);

    // Start-bit glitch: 4 ticks low
    b0 = bv_count;
    serial_in = 1'b0;
    repeat (4) @(negedge clk);
    serial_in = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch bytes", 32'(bv_count - b0), 32'd0);
    check("glitch busy", 32'(busy), 32'd0);
    check("glitch err_cnt", 32'(err_cnt), 32'd3);

    // Mid-frame timeout after A5 01
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (50) @(negedge clk);
    check("timeout busy before", 32'(busy), 32'd1);
    repeat (650) @(negedge clk);
    check("timeout busy after", 32'(busy), 32'd0);
    check("timeout err_cnt", 32'(err_cnt), 32'd4);

    // Drive err_cnt past 255 with aborted frames
    for (int n = 0; n < 252; n++) begin
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b0);
    end
    repeat (4) @(negedge clk);
    check("sat err_cnt", 32'(err_cnt), 32'hFF);
    check("sat cpu_hold", 32'(cpu_hold), 32'd0);

    // Asynchronous reset in the middle of a byte
    send_byte(8'hA5, 1'b1);
    serial_in = 1'b0;
    repeat (16) @(negedge clk);
    serial_in = 1'b1;
    repeat (48) @(negedge clk);
    check("midbyte busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async rst mem_we",   32'(mem_we),   32'd0);
    check("async rst mem_addr", mem_addr,      32'd0);
    check("async rst mem_wd",   mem_wd,        32'd0);
    check("async rst cpu_hold", 32'(cpu_hold), 32'd1);
    check("async rst busy",     32'(busy),     32'd0);
    check("async rst err_cnt",  32'(err_cnt),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    w0 = we_pulses;
    send_frame(8'h01, 32'h0000_0080, 32'h55AA_55AA, 1'b0, 8'h00);
    check("post rst we_pulses", 32'(we_pulses - w0), 32'd1);
    check("post rst mem_addr", mem_addr, 32'h0000_0080);
    check("post rst mem_wd", mem_wd, 32'h55AA_55AA);
    check("post rst err_cnt", 32'(err_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
